// File: rtl/aes_stream_requester.sv
// Host-side initiator for the AES accelerator stream protocol: frames a request
// (command, key, optional IV, payload) and forwards/length-checks the result stream.
module aes_stream_requester #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BLK_CNT_WIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [AXIS_TDATA_WIDTH-1:0] cmd_word,
  input  logic [127:0]                key,
  input  logic [127:0]                iv,
  input  logic                        use_iv,
  input  logic [BLK_CNT_WIDTH-1:0]    num_blocks,
  input  logic                        src_tvalid,
  output logic                        src_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] src_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_tdata,
  output logic [3:0]                  m_tstrb,
  output logic                        m_tlast,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_tdata,
  input  logic                        s_tlast,
  output logic                        dst_tvalid,
  input  logic                        dst_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] dst_tdata,
  output logic                        dst_tlast,
  output logic                        busy,
  output logic                        done,
  output logic                        err_len
);

  localparam int CW = BLK_CNT_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, CMD, KEY, IV, PAYLOAD, WAIT_RX} state_t;

  // Most-significant 32-bit word of a 128-bit value is word 0.
  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
    case (i)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  state_t          state;
  logic [1:0]      idx;
  logic [127:0]    key_q;
  logic [127:0]    iv_q;
  logic            use_iv_q;
  logic [CW-1:0]   pay_rem;

  logic            ld;
  logic            start_acc;
  logic            src_fire;

  logic            rx_armed;
  logic            rx_drain;
  logic            rx_done;
  logic [CW-1:0]   rx_cnt;
  logic [CW-1:0]   rx_exp;
  logic            rx_last_word;
  logic            rx_fire;

  // The state names the word to be loaded next, so a phase change costs no bubble.
  assign ld         = !m_tvalid || m_tready;
  assign start_acc  = (state == IDLE) && start;
  assign src_tready = (state == PAYLOAD) && ld && (pay_rem != '0);
  assign src_fire   = src_tvalid && src_tready;
  assign m_tstrb    = 4'hF;

  // NOTE: every register in a clocked block uses <= so all of them see pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      idx      <= '0;
      key_q    <= '0;
      iv_q     <= '0;
      use_iv_q <= 1'b0;
      pay_rem  <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_q    <= key;
            iv_q     <= iv;
            use_iv_q <= use_iv;
            pay_rem  <= {num_blocks, 2'b00};
            m_tdata  <= cmd_word;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            busy     <= 1'b1;
            state    <= CMD;
          end
        end
        CMD: begin
          if (ld) begin
            m_tdata <= word_of(key_q, 2'd0);
            idx     <= 2'd1;
            state   <= KEY;
          end
        end
        KEY: begin
          if (ld) begin
            m_tdata <= word_of(key_q, idx);
            if (idx == 2'd3) begin
              idx     <= 2'd0;
              m_tlast <= !use_iv_q && (pay_rem == '0);
              if (use_iv_q)           state <= IV;
              else if (pay_rem == '0) state <= WAIT_RX;
              else                    state <= PAYLOAD;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        IV: begin
          if (ld) begin
            m_tdata <= word_of(iv_q, idx);
            if (idx == 2'd3) begin
              idx     <= 2'd0;
              m_tlast <= (pay_rem == '0);
              if (pay_rem == '0) state <= WAIT_RX;
              else               state <= PAYLOAD;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        PAYLOAD: begin
          if (src_fire) begin
            m_tdata  <= src_tdata;
            m_tvalid <= 1'b1;
            m_tlast  <= (pay_rem == CW'(1));
            pay_rem  <= pay_rem - CW'(1);
            if (pay_rem == CW'(1)) state <= WAIT_RX;
          end else if (ld) begin
            // Source gap: the previous word left, nothing new to present.
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
          end
        end
        WAIT_RX: begin
          if (ld) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            if (rx_done) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result path is pure pass-through while armed; DRAIN swallows the overrun.
  assign rx_last_word = (rx_cnt == rx_exp - CW'(1));
  assign s_tready     = rx_armed ? dst_tready : rx_drain;
  assign dst_tvalid   = rx_armed && s_tvalid;
  assign dst_tdata    = s_tdata;
  assign dst_tlast    = rx_armed && (rx_last_word || s_tlast);
  assign rx_fire      = s_tvalid && s_tready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_armed <= 1'b0;
      rx_drain <= 1'b0;
      rx_done  <= 1'b0;
      rx_cnt   <= '0;
      rx_exp   <= '0;
      err_len  <= 1'b0;
    end else if (start_acc) begin
      err_len  <= 1'b0;
      rx_exp   <= {num_blocks, 2'b00};
      rx_cnt   <= '0;
      rx_drain <= 1'b0;
      rx_armed <= (num_blocks != '0);
      rx_done  <= (num_blocks == '0);
    end else if (rx_armed) begin
      if (rx_fire) begin
        if (rx_last_word) begin
          rx_armed <= 1'b0;
          if (s_tlast) begin
            rx_done <= 1'b1;
          end else begin
            err_len  <= 1'b1;
            rx_drain <= 1'b1;
          end
        end else if (s_tlast) begin
          rx_armed <= 1'b0;
          rx_done  <= 1'b1;
          err_len  <= 1'b1;
        end else begin
          rx_cnt <= rx_cnt + CW'(1);
        end
      end
    end else if (rx_drain) begin
      if (rx_fire && s_tlast) begin
        rx_drain <= 1'b0;
        rx_done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_stream_requester.sv
// Randomized scoreboard bench for aes_stream_requester: a frame/length model fills
// expected queues, and independent monitors pop them on every observed handshake.
module tb_aes_stream_requester;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [31:0]  cmd_word;
  logic [127:0] key;
  logic [127:0] iv;
  logic         use_iv;
  logic [15:0]  num_blocks;
  logic         src_tvalid, src_tready;
  logic [31:0]  src_tdata;
  logic         m_tvalid, m_tready, m_tlast;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tstrb;
  logic         s_tvalid, s_tready, s_tlast;
  logic [31:0]  s_tdata;
  logic         dst_tvalid, dst_tready, dst_tlast;
  logic [31:0]  dst_tdata;
  logic         busy, done, err_len;

  always #5 clk = ~clk;

  aes_stream_requester #(.AXIS_TDATA_WIDTH(32), .BLK_CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .cmd_word(cmd_word), .key(key), .iv(iv),
    .use_iv(use_iv), .num_blocks(num_blocks),
    .src_tvalid(src_tvalid), .src_tready(src_tready), .src_tdata(src_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tlast(m_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .dst_tvalid(dst_tvalid), .dst_tready(dst_tready), .dst_tdata(dst_tdata), .dst_tlast(dst_tlast),
    .busy(busy), .done(done), .err_len(err_len)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_m[$];
  beat_t       exp_dst[$];
  logic [31:0] src_q[$];
  logic [31:0] resp_q[$];

  int n_tests  = 0;
  int n_fail   = 0;
  int m_hs_cnt = 0;
  int done_cnt = 0;
  bit bp       = 1'b0;
  bit abort    = 1'b0;
  bit no_rx    = 1'b0;

  logic        stalled = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t make_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    return b;
  endfunction

  // Ready generators: random under backpressure, always ready otherwise.
  initial begin
    m_tready   = 1'b0;
    dst_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      dst_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Transmit monitor: handshake observed at negedge completes on the next posedge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("m_hold_valid", m_tvalid, 1);
          check("m_hold_word", {m_tlast, m_tdata}, {hold_last, hold_data});
        end
        if (m_tvalid && m_tready) begin
          if (exp_m.size() == 0) begin
            check("m_unexpected_word", m_tvalid, 0);
          end else begin
            e = exp_m.pop_front();
            check("m_tdata", m_tdata, e.data);
            check("m_tlast", m_tlast, e.last);
            check("m_tstrb", m_tstrb, 4'hF);
          end
          m_hs_cnt++;
        end
        stalled   = m_tvalid && !m_tready;
        hold_data = m_tdata;
        hold_last = m_tlast;
      end
    end
  end

  // Result monitor.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (dst_tvalid && dst_tready) begin
          if (exp_dst.size() == 0) begin
            check("dst_unexpected_word", dst_tvalid, 0);
          end else begin
            e = exp_dst.pop_front();
            check("dst_tdata", dst_tdata, e.data);
            check("dst_tlast", dst_tlast, e.last);
          end
        end
        if (no_rx) check("s_tready_idle", s_tready, 0);
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic src_drive(input bit bpx);
    int idx = 0;
    int guard = 0;
    bit hs;
    while (idx < src_q.size() && guard < 4000 && !abort) begin
      if (!src_tvalid && (!bpx || $urandom_range(0, 2) != 0)) begin
        src_tvalid = 1'b1;
        src_tdata  = src_q[idx];
      end
      @(negedge clk);
      hs = src_tvalid && src_tready;
      @(posedge clk);
      #1;
      if (hs) begin
        idx++;
        src_tvalid = 1'b0;
        src_tdata  = $urandom;
      end
      guard++;
    end
    src_tvalid = 1'b0;
    if (!abort) check("src_all_sent", idx, src_q.size());
  endtask

  task automatic respond(input int offend, input bit exp_err, input bit bpx);
    int idx = 0;
    int guard = 0;
    bit hs;
    while (idx < resp_q.size() && guard < 4000) begin
      if (!s_tvalid && (!bpx || $urandom_range(0, 2) != 0)) begin
        s_tvalid = 1'b1;
        s_tdata  = resp_q[idx];
        s_tlast  = (idx == resp_q.size() - 1);
      end
      @(negedge clk);
      hs = s_tvalid && s_tready;
      if (hs && exp_err && (idx + 1 == offend)) check("err_len_before", err_len, 0);
      @(posedge clk);
      #1;
      if (hs) begin
        if (exp_err && (idx + 1 == offend)) check("err_len_set", err_len, 1);
        idx++;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
      guard++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("resp_all_sent", idx, resp_q.size());
  endtask

  // Builds the expected frame and result from the request rules, then pulses start.
  task automatic issue(input bit ui, input int nb, input int rl, output int offend, output bit exp_err);
    logic [31:0]  cmd;
    logic [127:0] k, v;
    logic [31:0]  words[$];
    int ew, fwd;
    cmd = $urandom;
    k   = {$urandom, $urandom, $urandom, $urandom};
    v   = {$urandom, $urandom, $urandom, $urandom};
    src_q.delete();
    resp_q.delete();
    words.push_back(cmd);
    for (int i = 0; i < 4; i++) words.push_back(k[127-32*i -: 32]);
    if (ui) for (int i = 0; i < 4; i++) words.push_back(v[127-32*i -: 32]);
    for (int i = 0; i < 4 * nb; i++) begin
      src_q.push_back($urandom);
      words.push_back(src_q[i]);
    end
    for (int i = 0; i < words.size(); i++) exp_m.push_back(make_beat(words[i], i == words.size() - 1));
    ew  = 4 * nb;
    fwd = (ew == 0) ? 0 : ((rl < ew) ? rl : ew);
    for (int i = 0; i < rl; i++) resp_q.push_back($urandom);
    for (int i = 0; i < fwd; i++) exp_dst.push_back(make_beat(resp_q[i], i == fwd - 1));
    exp_err = (ew != 0) && (rl != ew);
    offend  = fwd;

    @(posedge clk);
    #1;
    cmd_word   = cmd;
    key        = k;
    iv         = v;
    use_iv     = ui;
    num_blocks = 16'(nb);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    cmd_word   = $urandom;
    key        = {$urandom, $urandom, $urandom, $urandom};
    iv         = {$urandom, $urandom, $urandom, $urandom};
    use_iv     = ~ui;
    num_blocks = 16'($urandom_range(0, 7));
    check("start_busy", busy, 1);
    check("start_m_tvalid", m_tvalid, 1);
    check("start_m_tdata", m_tdata, cmd);
    check("start_err_clear", err_len, 0);
  endtask

  task automatic run_req(input bit ui, input int nb, input int rl, input bit bpx);
    int  offend;
    bit  exp_err;
    int  dc0;
    bp  = bpx;
    dc0 = done_cnt;
    issue(ui, nb, rl, offend, exp_err);
    fork
      src_drive(bpx);
      respond(offend, exp_err, bpx);
      begin
        // A start while busy, with different inputs, must not disturb the frame.
        @(posedge clk);
        #1;
        start      = 1'b1;
        cmd_word   = $urandom;
        num_blocks = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      begin
        int c;
        c = 0;
        while (!done && c < 3000) begin
          @(negedge clk);
          c++;
        end
        check("done_seen", done, 1);
        check("tx_words_left", exp_m.size(), 0);
        check("dst_words_left", exp_dst.size(), 0);
        @(negedge clk);
        check("done_one_pulse", done, 0);
        check("busy_cleared", busy, 0);
        check("err_len", err_len, exp_err);
      end
    join
    check("done_count", done_cnt - dc0, 1);
    exp_m.delete();
    exp_dst.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_m_tlast"}, m_tlast, 0);
    check({tag, "_m_tdata"}, m_tdata, 0);
    check({tag, "_src_tready"}, src_tready, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_dst_tvalid"}, dst_tvalid, 0);
    check({tag, "_dst_tlast"}, dst_tlast, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_len"}, err_len, 0);
  endtask

  task automatic reset_test();
    int offend;
    bit exp_err;
    int target;
    bp = 1'b0;
    issue(1'b1, 4, 0, offend, exp_err);
    target = m_hs_cnt + 12;
    fork
      src_drive(1'b0);
      begin
        int c;
        c = 0;
        while (m_hs_cnt < target && c < 500) begin
          @(negedge clk);
          c++;
        end
        check("rst_reached_payload", m_hs_cnt >= target, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        abort = 1'b1;
        exp_m.delete();
        exp_dst.delete();
      end
    join
    abort      = 1'b0;
    src_tvalid = 1'b0;
    @(negedge clk);
    #3;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int nb, ew, mode, rl;
    resetn     = 1'b0;
    start      = 1'b0;
    cmd_word   = '0;
    key        = '0;
    iv         = '0;
    use_iv     = 1'b0;
    num_blocks = '0;
    src_tvalid = 1'b0;
    src_tdata  = '0;
    s_tvalid   = 1'b0;
    s_tdata    = '0;
    s_tlast    = 1'b0;
    #12;
    check_all_zero("reset");
    #11;
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    run_req(1'b1, 2, 8, 1'b0);              // nominal CBC-style
    no_rx = 1'b1;
    run_req(1'b0, 0, 0, 1'b0);              // header-only
    no_rx = 1'b0;
    run_req(1'b1, 2, 4, 1'b0);              // early tlast on word 4
    run_req(1'b0, 1, 6, 1'b0);              // missing tlast, 2 words drained

    for (int t = 0; t < 8; t++) begin
      nb   = $urandom_range(1, 3);
      ew   = 4 * nb;
      mode = $urandom_range(0, 2);
      if (mode == 0)      rl = ew;
      else if (mode == 1) rl = $urandom_range(1, ew - 1);
      else                rl = ew + $urandom_range(1, 3);
      run_req(1'($urandom_range(0, 1)), nb, rl, 1'b1);
    end

    reset_test();
    run_req(1'b1, 2, 8, 1'b1);
    run_req(1'b0, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
